bot_stream_feeder: RTL
======================

BOT_STREAM_FEEDER -- requirements
Module: bot_stream_feeder

Interface
REQ-001 SHALL have parameter SUM_FIFO_DEPTH_LOG2, default 2, log2 depth of the batch-sum output FIFO.
REQ-002 SHALL have parameter FREEZE_MARGIN, default 2, free FIFO slots below which freeze asserts.
REQ-003 clk  in  1  clock; all logic on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 srcValid  in  1  upstream graph valid.
REQ-006 srcReady  out  1  feeder accepts graph this cycle.
REQ-007 srcGraph  in  128  graph to send.
REQ-008 srcLast  in  1  graph is last of its batch.
REQ-009 isBotValid  out  1  to core, bot valid.
REQ-010 graphOut  out  128  to core graph input.
REQ-011 batchDoneOut  out  1  to core extra data, last-of-batch marker.
REQ-012 freezeCore  out  1  to core, halts core's index and result stream.
REQ-013 coreAlmostFull  in  1  from core input FIFO.
REQ-014 resultValid  in  1  from core, result present.
REQ-015 connectCount  in  6  from core, connected-component count.
REQ-016 resultBatchDone  in  1  from core, echoed last-of-batch marker.
REQ-017 coreEcc  in  1  from core ECC status.
REQ-018 sumValid / sumReady  out / in  1 / 1  batch-sum output handshake.
REQ-019 sumData  out  64  sum of 2^connectCount over one batch.
REQ-020 inFlight  out  16  bots sent minus results received.
REQ-021 errSticky  out  1  sticky ECC/overflow error.

Function
REQ-022 srcReady SHALL equal !rst && !coreAlmostFull && !freezeCore (combinational).
REQ-023 Transfer = srcValid && srcReady; next cycle isBotValid=1, graphOut=srcGraph, batchDoneOut=srcLast (latency 1).
REQ-024 Without transfer, next cycle isBotValid=0, graphOut=0, batchDoneOut=0 (bubble, must still be driven every cycle).
REQ-025 freezeCore SHALL be registered: 1 when FIFO free slots < FREEZE_MARGIN, else 0.
REQ-026 On resultValid: term = 64'b1 << connectCount; connectCount >= 64 impossible (6 bits); connectCount > 40 sets errSticky but is still accumulated modulo 2^64.
REQ-027 resultValid && !resultBatchDone: acc <= acc + term.
REQ-028 resultValid && resultBatchDone: push acc + term into FIFO, acc <= 0 same cycle.
REQ-029 Push into full FIFO SHALL drop the value and set errSticky; acc still clears.
REQ-030 sumValid = FIFO not empty; sumData = FIFO head; pop when sumValid && sumReady; simultaneous push and pop on full FIFO SHALL succeed without error.
REQ-031 inFlight increments on isBotValid, decrements on resultValid, unchanged when both; saturates at 0 and 65535, either saturation sets errSticky.
REQ-032 errSticky <= errSticky | coreEcc each cycle; cleared only by rst.
REQ-033 resultValid SHALL be honoured while freezeCore=1 (core delivers up to 2 results after freeze).

Reset
REQ-034 During rst: srcReady=0, isBotValid=0, graphOut=0, batchDoneOut=0, freezeCore=0, acc=0, FIFO empty (sumValid=0), sumData=0, inFlight=0, errSticky=0.
REQ-035 rst mid-batch SHALL discard partial acc and FIFO contents; first cycle after rst deassert is ready if coreAlmostFull=0.

Structure
REQ-036 Shared package SHALL hold GRAPH_WIDTH=128, COUNT_WIDTH=6, SUM_WIDTH=64, INFLIGHT_WIDTH=16, OVERFLOW_COUNT_LIMIT=40.
REQ-037 One sub-module: bot_sum_fifo (single-clock, registered-output FIFO, depth 2^SUM_FIFO_DEPTH_LOG2, count output).

Verification
REQ-038 3 graphs, srcLast on 3rd, coreAlmostFull=0 -> isBotValid 1 cycle later each, batchDoneOut=1 only on 3rd, inFlight=3.
REQ-039 Results counts 2,3,5 with done on 5 -> sumData=44 (4+8+32), sumValid=1, acc=0, inFlight=0.
REQ-040 coreAlmostFull=1 with srcValid=1 for 10 cycles -> srcReady=0, no isBotValid, graph accepted first cycle after release.
REQ-041 sumReady=0, 3 batches complete (depth 4, margin 2) -> freezeCore=1 cycle after 3rd push; 2 further results absorbed; 5th push drops, errSticky=1.
REQ-042 Single result count 41 with done -> sumData=2^41, errSticky=1; coreEcc pulse 1 cycle -> errSticky stays 1 until rst.
REQ-043 rst asserted mid-batch after 2 results -> all outputs at REQ-034 values; next batch count 0 alone -> sumData=1.

Source files
------------

// File: rtl/bot_stream_feeder_pkg.sv
// Shared widths and helpers for the bot stream feeder.
// Imported by the feeder top and its batch-sum FIFO.
package bot_stream_feeder_pkg;

  localparam int GRAPH_WIDTH          = 128;
  localparam int COUNT_WIDTH          = 6;
  localparam int SUM_WIDTH            = 64;
  localparam int INFLIGHT_WIDTH       = 16;
  localparam int OVERFLOW_COUNT_LIMIT = 40;

  // One component count contributes 2^count to its batch sum.
  function automatic logic [SUM_WIDTH-1:0] count_term(
    input logic [COUNT_WIDTH-1:0] c
  );
    return SUM_WIDTH'(1) << c;
  endfunction

endpackage

// File: rtl/bot_sum_fifo.sv
// Single-clock FIFO for completed batch sums.
// Head is read straight from storage flops; zero when empty.
module bot_sum_fifo
  import bot_stream_feeder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [SUM_WIDTH-1:0]  push_data,
  input  logic                  pop,
  output logic [SUM_WIDTH-1:0]  head,
  output logic                  empty,
  output logic                  full,
  output logic                  dropped,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [SUM_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop_ok;
  logic                  accept;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot a full push needs.
  assign accept  = push && (!full || pop_ok);
  assign dropped = push && !accept;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are qualified by count, so no reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop_ok) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (accept && !pop_ok)
        count <= count + CW'(1);
      else if (!accept && pop_ok)
        count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/bot_stream_feeder.sv
// Feeds graphs to the bot core and sums 2^count per batch.
// Tracks bots in flight and latches any error until reset.
module bot_stream_feeder
  import bot_stream_feeder_pkg::*;
#(
  parameter int SUM_FIFO_DEPTH_LOG2 = 2,
  parameter int FREEZE_MARGIN       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      srcValid,
  output logic                      srcReady,
  input  logic [GRAPH_WIDTH-1:0]    srcGraph,
  input  logic                      srcLast,
  output logic                      isBotValid,
  output logic [GRAPH_WIDTH-1:0]    graphOut,
  output logic                      batchDoneOut,
  output logic                      freezeCore,
  input  logic                      coreAlmostFull,
  input  logic                      resultValid,
  input  logic [COUNT_WIDTH-1:0]    connectCount,
  input  logic                      resultBatchDone,
  input  logic                      coreEcc,
  output logic                      sumValid,
  input  logic                      sumReady,
  output logic [SUM_WIDTH-1:0]      sumData,
  output logic [INFLIGHT_WIDTH-1:0] inFlight,
  output logic                      errSticky
);

  localparam int FIFO_DEPTH = 1 << SUM_FIFO_DEPTH_LOG2;

  logic                         xfer;
  logic [SUM_WIDTH-1:0]         acc;
  logic [SUM_WIDTH-1:0]         term;
  logic [SUM_WIDTH-1:0]         batch_sum;
  logic                         sum_push;
  logic                         sum_pop;
  logic                         fifo_empty;
  logic                         fifo_full;
  logic                         fifo_drop;
  logic [SUM_FIFO_DEPTH_LOG2:0] fifo_count;
  logic                         big_count;
  logic                         if_up;
  logic                         if_dn;
  logic                         if_sat;

  assign srcReady  = !rst && !coreAlmostFull && !freezeCore;
  assign xfer      = srcValid && srcReady;

  assign term      = count_term(connectCount);
  assign batch_sum = acc + term;
  assign sum_push  = resultValid && resultBatchDone;
  assign big_count = resultValid
                  && (connectCount > COUNT_WIDTH'(OVERFLOW_COUNT_LIMIT));

  assign sumValid  = !fifo_empty;
  assign sum_pop   = sumValid && sumReady;

  assign if_up  = isBotValid && !resultValid;
  assign if_dn  = resultValid && !isBotValid;
  assign if_sat = (if_up && (inFlight == '1))
               || (if_dn && (inFlight == '0));

  // Graph stage: one-cycle copy of an accepted graph, zeros otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      isBotValid   <= 1'b0;
      graphOut     <= '0;
      batchDoneOut <= 1'b0;
    end else begin
      isBotValid   <= xfer;
      graphOut     <= xfer ? srcGraph : '0;
      batchDoneOut <= xfer && srcLast;
    end
  end

  // Batch accumulator; clears whenever a batch closes, pushed or dropped.
  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (sum_push)
      acc <= '0;
    else if (resultValid)
      acc <= batch_sum;
  end

  // Freeze the core once the sum FIFO is nearly out of room.
  always_ff @(posedge clk) begin
    if (rst)
      freezeCore <= 1'b0;
    else
      freezeCore <= (FIFO_DEPTH - int'(fifo_count)) < FREEZE_MARGIN;
  end

  // Saturating count of bots issued but not yet answered.
  always_ff @(posedge clk) begin
    if (rst)
      inFlight <= '0;
    else if (if_up && !if_sat)
      inFlight <= inFlight + INFLIGHT_WIDTH'(1);
    else if (if_dn && !if_sat)
      inFlight <= inFlight - INFLIGHT_WIDTH'(1);
  end

  // Sticky error: ECC, oversized count, dropped sum or saturation.
  always_ff @(posedge clk) begin
    if (rst)
      errSticky <= 1'b0;
    else
      errSticky <= errSticky | coreEcc | big_count
                 | fifo_drop | if_sat;
  end

  bot_sum_fifo #(
    .DEPTH_LOG2 (SUM_FIFO_DEPTH_LOG2)
  ) u_sum_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sum_push),
    .push_data (batch_sum),
    .pop       (sum_pop),
    .head      (sumData),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .dropped   (fifo_drop),
    .count     (fifo_count)
  );

endmodule
